// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit processor sequencer: FSM states,
// instruction classes, ALU opcodes and instruction field positions.
package cpu4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    // Instruction class, ir[7:6]
    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_JNZ  = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    // ALU opcodes driven on alu_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Field LSB positions inside the 8-bit instruction word
    localparam int unsigned CLS_LSB     = 6;  // class, 2 bits
    localparam int unsigned ALU_OP_LSB  = 4;  // ALU op, 2 bits
    localparam int unsigned ALU_RD_LSB  = 2;  // ALU destination, 2 bits
    localparam int unsigned ALU_RS_LSB  = 0;  // ALU source, 2 bits
    localparam int unsigned REG_HI_LSB  = 4;  // LDI rd / JNZ rs, 2 bits
    localparam int unsigned IMM_LSB     = 0;  // LDI imm / JNZ target, 4 bits

    function automatic logic [1:0] ir_class(input logic [7:0] ir);
        return ir[CLS_LSB +: 2];
    endfunction

endpackage

// File: rtl/cpu_seq_4bit_regfile.sv
// 4x4-bit register file: one synchronous write port, asynchronous clear,
// combinational reads for the operand pair and for the debug port.
module regfile_4x4
    import cpu4_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [3:0] wdata_i,
    input  logic [1:0] ra_addr_i,
    output logic [3:0] ra_data_o,
    input  logic [1:0] rb_addr_i,
    output logic [3:0] rb_data_o,
    input  logic [1:0] dbg_addr_i,
    output logic [3:0] dbg_data_o
);

    logic [3:0] mem_q [4];

    // Register storage: cleared by reset, written on the enabled edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = mem_q[ra_addr_i];
    assign rb_data_o  = mem_q[rb_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/cpu_seq_4bit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit
// processor. Drives the external combinational ALU and instruction ROM.
module cpu_seq_4bit
    import cpu4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_result,
    output logic       busy,
    output logic       halted,
    output logic       zero,
    input  logic [1:0] dbg_sel,
    output logic [3:0] dbg_data
);

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] res_q, res_d;
    logic       zero_q, zero_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_op_q, alu_op_d;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [1:0] opb_sel;
    logic [3:0] opa_data, opb_data;
    logic [1:0] cls;

    assign cls = ir_class(ir_q);

    // Operand B doubles as the JNZ test register, whose field sits in [5:4]
    assign opb_sel = (cls == CLS_JNZ) ? ir_q[REG_HI_LSB +: 2] : ir_q[ALU_RS_LSB +: 2];

    regfile_4x4 u_rf (
        .clk_i      (clk),
        .rst_i      (rst),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (res_q),
        .ra_addr_i  (ir_q[ALU_RD_LSB +: 2]),
        .ra_data_o  (opa_data),
        .rb_addr_i  (opb_sel),
        .rb_data_o  (opb_data),
        .dbg_addr_i (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    // Next-state, datapath update and register-file write control
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        res_d    = res_q;
        zero_d   = zero_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rf_we    = 1'b0;
        rf_waddr = ir_q[ALU_RD_LSB +: 2];

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls == CLS_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    if (cls == CLS_ALU) begin
                        alu_a_d  = opa_data;
                        alu_b_d  = opb_data;
                        alu_op_d = ir_q[ALU_OP_LSB +: 2];
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls == CLS_ALU) begin
                    res_d = alu_result;
                end else if (cls == CLS_LDI) begin
                    res_d = ir_q[IMM_LSB +: 4];
                end else begin
                    res_d = opb_data;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                if (cls == CLS_JNZ) begin
                    pc_d = (res_q != '0) ? ir_q[IMM_LSB +: 4] : pc_q + 4'd1;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = (cls == CLS_ALU) ? ir_q[ALU_RD_LSB +: 2] : ir_q[REG_HI_LSB +: 2];
                    zero_d   = (res_q == '0);
                    pc_d     = pc_q + 4'd1;
                end
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign zero      = zero_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_seq_4bit.sv
// Testbench for cpu_seq_4bit: behavioural instruction-set model, external
// ROM and ALU models, directed programs followed by random programs.
module tb_cpu_seq_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_op;
    logic       busy, halted, zero;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    logic [7:0] prog [16];

    int vectors = 0;
    int miscompares = 0;

    // Instruction-set level model state
    int m_reg [4];
    int m_pc, m_zero, m_halted, m_taken;

    int dut_back = 0;
    logic [3:0] last_addr = '0;

    cpu_seq_4bit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .halted     (halted),
        .zero       (zero),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    assign imem_data = prog[imem_addr];

    // External ALU
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = ~alu_a;
        endcase
    end

    // Count backward jumps from address 3 to address 2 (loop test)
    always @(negedge clk) begin
        if (imem_addr == 4'd2 && last_addr == 4'd3) dut_back++;
        last_addr = imem_addr;
    end

    function automatic logic [7:0] i_ldi(input int rd, input int imm);
        logic [1:0] r = rd[1:0];
        logic [3:0] v = imm[3:0];
        return {2'b01, r, v};
    endfunction

    function automatic logic [7:0] i_alu(input int op, input int rd, input int rs);
        logic [1:0] o = op[1:0];
        logic [1:0] d = rd[1:0];
        logic [1:0] s = rs[1:0];
        return {2'b00, o, d, s};
    endfunction

    function automatic logic [7:0] i_jnz(input int rs, input int tgt);
        logic [1:0] s = rs[1:0];
        logic [3:0] t = tgt[3:0];
        return {2'b10, s, t};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_zero = 0;
        m_pc = 0;
        m_halted = 0;
    endtask

    // Executes up to max_instr instructions from PC 0, returning elapsed cycles
    task automatic model_run(input int max_instr, output int cycles);
        int n, ir, cls, f54, f32, f10, lo, v;
        cycles = 0;
        m_pc = 0;
        m_halted = 0;
        m_taken = 0;
        n = 0;
        while (n < max_instr && m_halted == 0) begin
            ir  = int'(prog[m_pc]);
            cls = ir / 64;
            f54 = (ir / 16) % 4;
            f32 = (ir / 4) % 4;
            f10 = ir % 4;
            lo  = ir % 16;
            case (cls)
                0: begin
                    case (f54)
                        0:       v = (m_reg[f32] + m_reg[f10]) % 16;
                        1:       v = (m_reg[f32] - m_reg[f10] + 16) % 16;
                        2:       v = m_reg[f32] & m_reg[f10];
                        default: v = 15 - m_reg[f32];
                    endcase
                    m_reg[f32] = v;
                    m_zero = (v == 0);
                    m_pc = (m_pc + 1) % 16;
                    cycles += 4;
                end
                1: begin
                    m_reg[f54] = lo;
                    m_zero = (lo == 0);
                    m_pc = (m_pc + 1) % 16;
                    cycles += 4;
                end
                2: begin
                    if (m_reg[f54] != 0) begin
                        m_pc = lo;
                        m_taken++;
                    end else begin
                        m_pc = (m_pc + 1) % 16;
                    end
                    cycles += 4;
                end
                default: begin
                    m_halted = 1;
                    cycles += 2;
                end
            endcase
            n++;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'hC0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Called at a negedge; compares architectural state against the model
    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s r%0d", tag, i), 8'(dbg_data), 8'(m_reg[i]));
        end
        chk({tag, " zero"},   8'(zero),      8'(m_zero));
        chk({tag, " halted"}, 8'(halted),    8'(m_halted));
        chk({tag, " busy"},   8'(busy),      8'(m_halted == 0));
        chk({tag, " pc"},     8'(imem_addr), 8'(m_pc));
    endtask

    task automatic run_prog(input string tag, input int max_instr);
        int cyc;
        model_run(max_instr, cyc);
        pulse_start();
        repeat (cyc) @(negedge clk);
        check_state(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " imem_addr"}, 8'(imem_addr), 8'd0);
        chk({tag, " alu_a"},     8'(alu_a),     8'd0);
        chk({tag, " alu_b"},     8'(alu_b),     8'd0);
        chk({tag, " alu_op"},    8'(alu_op),    8'd0);
        chk({tag, " busy"},      8'(busy),      8'd0);
        chk({tag, " halted"},    8'(halted),    8'd0);
        chk({tag, " zero"},      8'(zero),      8'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s r%0d", tag, i), 8'(dbg_data), 8'd0);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        dbg_sel = '0;
        clear_prog();
        m_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic add program, with exact halt timing
        clear_prog();
        prog[0] = i_ldi(0, 5);
        prog[1] = i_ldi(1, 3);
        prog[2] = i_alu(0, 0, 1);
        model_run(32, cyc);
        chk("add busy before start", 8'(busy), 8'd0);
        pulse_start();
        chk("add busy in first fetch", 8'(busy), 8'd1);
        repeat (cyc - 1) @(negedge clk);
        chk("add halted one cycle early", 8'(halted), 8'd0);
        @(negedge clk);
        check_state("add");
        chk("add r0 value", 8'(m_reg[0]), 8'd8);

        // Subtract to zero
        clear_prog();
        prog[0] = i_ldi(2, 7);
        prog[1] = i_ldi(3, 7);
        prog[2] = i_alu(1, 2, 3);
        run_prog("sub0", 32);

        // Overflow wraps modulo 16
        clear_prog();
        prog[0] = i_ldi(0, 15);
        prog[1] = i_ldi(1, 1);
        prog[2] = i_alu(0, 0, 1);
        run_prog("ovf", 32);

        // Countdown loop
        clear_prog();
        prog[0] = i_ldi(0, 3);
        prog[1] = i_ldi(1, 1);
        prog[2] = i_alu(1, 0, 1);
        prog[3] = i_jnz(0, 2);
        dut_back = 0;
        run_prog("loop", 64);
        chk("loop jnz taken", 8'(dut_back), 8'(m_taken));

        // NOT then AND, observing ALU drive in EXEC
        clear_prog();
        prog[0] = i_ldi(0, 10);
        prog[1] = i_alu(3, 0, 0);
        prog[2] = i_ldi(1, 6);
        prog[3] = i_alu(2, 0, 1);
        model_run(32, cyc);
        pulse_start();
        repeat (6) @(negedge clk);
        chk("not alu_op", 8'(alu_op), 8'd3);
        chk("not alu_a",  8'(alu_a),  8'd10);
        repeat (2) @(negedge clk);
        dbg_sel = 2'd0;
        #1;
        chk("not r0", 8'(dbg_data), 8'd5);
        repeat (6) @(negedge clk);
        chk("and alu_op", 8'(alu_op), 8'd2);
        chk("and alu_a",  8'(alu_a),  8'd5);
        chk("and alu_b",  8'(alu_b),  8'd6);
        repeat (cyc - 14) @(negedge clk);
        check_state("notand");

        // Start pulse while busy is ignored
        clear_prog();
        prog[0] = i_ldi(0, 5);
        prog[1] = i_ldi(1, 3);
        prog[2] = i_alu(0, 0, 1);
        model_run(32, cyc);
        pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (cyc - 4) @(negedge clk);
        check_state("busy start");

        // Restart from HALT keeps register contents
        clear_prog();
        prog[0] = i_alu(0, 0, 1);
        run_prog("restart", 32);

        // No HALT: PC wraps 15 -> 0
        for (int i = 0; i < 16; i++) prog[i] = i_ldi(i % 4, i);
        run_prog("wrap", 18);

        // Reset during EXEC of ADD
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_reset();
        clear_prog();
        prog[0] = i_ldi(0, 5);
        prog[1] = i_ldi(1, 3);
        prog[2] = i_alu(0, 0, 1);
        pulse_start();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst exec");
        @(negedge clk) rst = 1'b0;
        m_reset();
        run_prog("after rst", 32);

        // Random programs; a program that is still running is stopped by reset
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
            run_prog($sformatf("rand%0d", t), 24);
            if (m_halted == 0) begin
                @(negedge clk) rst = 1'b1;
                @(negedge clk) rst = 1'b0;
                m_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
